// File: rtl/unified_mem_arb_if.sv
// Core-side bus for unified_mem_arb: instruction fetch port and data load/store port.
// master = core side, slave = memory/arbiter side.
interface unified_mem_arb_if #(
  parameter int MEM_WIDTH = 32
);
  logic [31:0]          mem_addr_instr;
  logic                 mem_read_en_instr;
  logic [MEM_WIDTH-1:0] mem_read_val_instr;
  logic                 instr_valid;
  logic [31:0]          mem_addr_data;
  logic                 mem_read_en_data;
  logic                 mem_write_en_data;
  logic [MEM_WIDTH-1:0] mem_write_val_data;
  logic [MEM_WIDTH-1:0] mem_read_val_data;
  logic                 data_valid;

  modport master (
    output mem_addr_instr,
    output mem_read_en_instr,
    input  mem_read_val_instr,
    input  instr_valid,
    output mem_addr_data,
    output mem_read_en_data,
    output mem_write_en_data,
    output mem_write_val_data,
    input  mem_read_val_data,
    input  data_valid
  );

  modport slave (
    input  mem_addr_instr,
    input  mem_read_en_instr,
    output mem_read_val_instr,
    output instr_valid,
    input  mem_addr_data,
    input  mem_read_en_data,
    input  mem_write_en_data,
    input  mem_write_val_data,
    output mem_read_val_data,
    output data_valid
  );
endinterface

// File: rtl/unified_mem_arb.sv
// Single-port unified RAM with round-robin I/D arbiter, one access per cycle.
// Optional: define UMEM_STAT_EN to add the saturating conflict_cnt output.
module unified_mem_arb #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_SIZE  = 256
) (
  input  logic             clk,
  input  logic             reset,
  unified_mem_arb_if.slave bus,
  output logic             addr_err
`ifdef UMEM_STAT_EN
  ,
  output logic [15:0]      conflict_cnt
`endif
);
  localparam int AW = $clog2(MEM_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    SERV_I,
    SERV_D
  } state_t;

  state_t state, state_nx;
  logic last_d;
  logic pend_i, pend_d;
  logic gnt_i, gnt_d;
  logic bad_i, bad_d;
  logic [AW-1:0] idx_i, idx_d;
  logic [MEM_WIDTH-1:0] ram [MEM_SIZE];
  logic [MEM_WIDTH-1:0] rd_i, rd_d;

  assign pend_i = bus.mem_read_en_instr;
  assign pend_d = bus.mem_read_en_data
                | bus.mem_write_en_data;

  assign idx_i = bus.mem_addr_instr[AW+1:2];
  assign idx_d = bus.mem_addr_data[AW+1:2];

  assign bad_i = (|bus.mem_addr_instr[1:0])
               | (|bus.mem_addr_instr[31:AW+2]);
  assign bad_d = (|bus.mem_addr_data[1:0])
               | (|bus.mem_addr_data[31:AW+2]);

  // Grant is re-evaluated every cycle regardless of the current state.
  always_comb begin
    gnt_i    = 1'b0;
    gnt_d    = 1'b0;
    state_nx = IDLE;
    if (pend_i && (!pend_d || last_d)) begin
      gnt_i    = 1'b1;
      state_nx = SERV_I;
    end else if (pend_d) begin
      gnt_d    = 1'b1;
      state_nx = SERV_D;
    end
  end

  always_comb begin
    bus.instr_valid        = 1'b0;
    bus.data_valid         = 1'b0;
    bus.mem_read_val_instr = rd_i;
    bus.mem_read_val_data  = rd_d;
    unique case (state)
      SERV_I:  bus.instr_valid = 1'b1;
      SERV_D:  bus.data_valid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last_d   <= 1'b1;
      rd_i     <= '0;
      rd_d     <= '0;
      addr_err <= 1'b0;
    end else begin
      state    <= state_nx;
      addr_err <= addr_err
                | (gnt_i & bad_i)
                | (gnt_d & bad_d);
      if (gnt_i) begin
        last_d <= 1'b0;
        rd_i   <= bad_i ? '0 : ram[idx_i];
      end
      if (gnt_d) begin
        last_d <= 1'b1;
        if (bus.mem_read_en_data) begin
          if (bad_d)
            rd_d <= '0;
          else if (bus.mem_write_en_data)
            rd_d <= bus.mem_write_val_data;
          else
            rd_d <= ram[idx_d];
        end
      end
    end
  end

  // RAM has no reset; a write granted on a reset edge is suppressed.
  always_ff @(posedge clk) begin
    if (!reset && gnt_d && bus.mem_write_en_data && !bad_d)
      ram[idx_d] <= bus.mem_write_val_data;
  end

`ifdef UMEM_STAT_EN
  always_ff @(posedge clk) begin
    if (reset)
      conflict_cnt <= '0;
    else if (pend_i && pend_d && conflict_cnt != 16'hFFFF)
      conflict_cnt <= conflict_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_unified_mem_arb.sv
// Randomised + directed bench for unified_mem_arb against a behavioural model.
// Works with or without UMEM_STAT_EN defined.
module tb_unified_mem_arb;
  logic clk = 1'b0;
  logic reset;
  logic addr_err;
`ifdef UMEM_STAT_EN
  logic [15:0] conflict_cnt;
`endif

  always #5 clk = ~clk;

  unified_mem_arb_if #(.MEM_WIDTH(32)) bus ();

  unified_mem_arb #(
    .MEM_WIDTH(32),
    .MEM_SIZE (256)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .addr_err(addr_err)
`ifdef UMEM_STAT_EN
    ,
    .conflict_cnt(conflict_cnt)
`endif
  );

  int total = 0;
  int bad = 0;

  logic [31:0] m_mem [256];
  bit          m_last_was_d;
  bit          e_iv, e_dv, e_err;
  logic [31:0] e_ri, e_rd;
  int          e_cnt;

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd1024);
  endfunction

  function automatic logic [31:0] pat(input int i);
    return (i * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model one clock edge from the currently driven inputs, then check.
  task automatic step();
    bit pi, pd, gi, gd;
    logic [31:0] a;
    pi = bus.mem_read_en_instr;
    pd = bus.mem_read_en_data || bus.mem_write_en_data;
    if (reset) begin
      e_iv = 0; e_dv = 0; e_err = 0;
      e_ri = 0; e_rd = 0; e_cnt = 0;
      m_last_was_d = 1;
    end else begin
      if (pi && pd && e_cnt < 65535) e_cnt++;
      gi = pi && (!pd || m_last_was_d);
      gd = pd && !gi;
      e_iv = gi;
      e_dv = gd;
      if (gi) begin
        a = bus.mem_addr_instr;
        m_last_was_d = 0;
        if (is_bad(a)) begin
          e_err = 1; e_ri = 0;
        end else e_ri = m_mem[a / 4];
      end
      if (gd) begin
        a = bus.mem_addr_data;
        m_last_was_d = 1;
        if (is_bad(a)) e_err = 1;
        if (bus.mem_write_en_data && !is_bad(a))
          m_mem[a / 4] = bus.mem_write_val_data;
        if (bus.mem_read_en_data)
          e_rd = is_bad(a) ? 32'h0 : m_mem[a / 4];
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("instr_valid", {31'b0, bus.instr_valid}, {31'b0, e_iv});
    chk("data_valid", {31'b0, bus.data_valid}, {31'b0, e_dv});
    chk("addr_err", {31'b0, addr_err}, {31'b0, e_err});
    chk("rd_instr", bus.mem_read_val_instr, e_ri);
    chk("rd_data", bus.mem_read_val_data, e_rd);
`ifdef UMEM_STAT_EN
    chk("conflict_cnt", {16'b0, conflict_cnt}, e_cnt);
`endif
  endtask

  task automatic do_d(input logic [31:0] a, input bit r, input bit w,
                      input logic [31:0] wd);
    int n = 0;
    bus.mem_addr_data      = a;
    bus.mem_read_en_data   = r;
    bus.mem_write_en_data  = w;
    bus.mem_write_val_data = wd;
    while (n < 4 && !e_dv) begin
      step();
      n++;
    end
    chk("d_latency", n, 1);
    bus.mem_read_en_data  = 0;
    bus.mem_write_en_data = 0;
    e_dv = 0;
  endtask

  task automatic do_i(input logic [31:0] a);
    int n = 0;
    bus.mem_addr_instr    = a;
    bus.mem_read_en_instr = 1;
    while (n < 4 && !e_iv) begin
      step();
      n++;
    end
    chk("i_latency", n, 1);
    bus.mem_read_en_instr = 0;
    e_iv = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 15);
    logic [31:0] i = 32'($urandom_range(0, 255));
    if (r == 0) return i * 4 + 32'($urandom_range(1, 3));
    if (r == 1) return 32'h400 + i * 4;
    return i * 4;
  endfunction

  initial begin
    bus.mem_addr_instr     = 0;
    bus.mem_read_en_instr  = 0;
    bus.mem_addr_data      = 0;
    bus.mem_read_en_data   = 0;
    bus.mem_write_en_data  = 0;
    bus.mem_write_val_data = 0;
    reset = 1;
    step();
    step();
    reset = 0;
    chk("rst_ri", bus.mem_read_val_instr, 32'h0);
    chk("rst_err", {31'b0, addr_err}, 32'h0);

    for (int i = 0; i < 256; i++) do_d(32'(i * 4), 0, 1, pat(i));

    // store then load
    do_d(32'h10, 0, 1, 32'hDEADBEEF);
    do_d(32'h10, 1, 0, 32'h0);
    chk("load_10", bus.mem_read_val_data, 32'hDEADBEEF);

    // back-to-back fetches
    bus.mem_read_en_instr = 1;
    for (int k = 0; k < 3; k++) begin
      bus.mem_addr_instr = 32'(k * 4);
      step();
      chk("b2b_iv", {31'b0, bus.instr_valid}, 32'h1);
      chk("b2b_word", bus.mem_read_val_instr, pat(k));
    end
    bus.mem_read_en_instr = 0;
    step();

    // write-first read+write
    do_d(32'h20, 1, 1, 32'h12345678);
    chk("rw_20", bus.mem_read_val_data, 32'h12345678);

    // bad addresses
    do_d(32'h13, 1, 0, 32'h0);
    chk("bad_ld", bus.mem_read_val_data, 32'h0);
    chk("bad_err", {31'b0, addr_err}, 32'h1);
    do_d(32'h400, 0, 1, 32'h1);
    for (int i = 0; i < 256; i++) do_i(32'(i * 4));
    chk("err_sticky", {31'b0, addr_err}, 32'h1);

    // reset during SERV_D
    bus.mem_addr_data      = 32'h30;
    bus.mem_write_en_data  = 1;
    bus.mem_write_val_data = 32'hCAFEF00D;
    step();
    chk("pre_rst_dv", {31'b0, bus.data_valid}, 32'h1);
    bus.mem_addr_data      = 32'h34;
    bus.mem_write_val_data = 32'hBAD0BAD0;
    reset = 1;
    step();
    chk("rst_dv", {31'b0, bus.data_valid}, 32'h0);
    chk("rst_rd", bus.mem_read_val_data, 32'h0);
    chk("rst_err2", {31'b0, addr_err}, 32'h0);
    reset = 0;
    bus.mem_write_en_data = 0;
    do_d(32'h34, 1, 0, 32'h0);
    chk("rst_keep34", bus.mem_read_val_data, pat(13));
    do_d(32'h30, 1, 0, 32'h0);
    chk("rst_keep30", bus.mem_read_val_data, 32'hCAFEF00D);

    // contention from reset
    reset = 1;
    bus.mem_addr_instr    = 32'h8;
    bus.mem_read_en_instr = 1;
    bus.mem_addr_data     = 32'h40;
    bus.mem_read_en_data  = 1;
    step();
    reset = 0;
    for (int j = 0; j < 8; j++) begin
      step();
      chk("ctn_iv", {31'b0, bus.instr_valid}, (j % 2 == 0) ? 1 : 0);
      chk("ctn_dv", {31'b0, bus.data_valid}, (j % 2 == 1) ? 1 : 0);
`ifdef UMEM_STAT_EN
      chk("ctn_cnt", {16'b0, conflict_cnt}, j + 1);
`endif
    end

    // randomised traffic holding each request until its valid
    for (int c = 0; c < 600; c++) begin
      if (!bus.mem_read_en_instr || e_iv) begin
        bus.mem_read_en_instr = ($urandom_range(0, 3) != 0);
        bus.mem_addr_instr    = rand_addr();
      end
      if (!(bus.mem_read_en_data || bus.mem_write_en_data) || e_dv) begin
        case ($urandom_range(0, 4))
          0: begin
            bus.mem_read_en_data = 0; bus.mem_write_en_data = 0;
          end
          1, 2: begin
            bus.mem_read_en_data = 1; bus.mem_write_en_data = 0;
          end
          3: begin
            bus.mem_read_en_data = 0; bus.mem_write_en_data = 1;
          end
          default: begin
            bus.mem_read_en_data = 1; bus.mem_write_en_data = 1;
          end
        endcase
        bus.mem_addr_data      = rand_addr();
        bus.mem_write_val_data = $urandom;
      end
      if (c == 300) reset = 1;
      if (c == 302) reset = 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/unified_mem_arb.md
# unified_mem_arb

Single-port unified memory with a two-requester arbiter that sits directly downstream of the MIPS `Core`. It serves the core's instruction-fetch port and data load/store port from one word-organised synchronous RAM. Exactly one access is performed per cycle, and each requester gets a one-cycle `valid` pulse when its access completes. The core stalls on each port until that port's `valid` is seen.

## Interface
- `MEM_WIDTH`, 32: data word width in bits.
- `MEM_SIZE`, 256: RAM depth in words; must be a power of two ≥ 4.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_addr_instr` in 32: byte address for instruction fetch.
- `mem_read_en_instr` in 1: fetch request (level).
- `mem_read_val_instr` out MEM_WIDTH: fetched word.
- `instr_valid` out 1: one-cycle pulse; `mem_read_val_instr` is valid.
- `mem_addr_data` in 32: byte address for load/store.
- `mem_read_en_data` in 1: load request (level).
- `mem_write_en_data` in 1: store request (level).
- `mem_write_val_data` in MEM_WIDTH: store data.
- `mem_read_val_data` out MEM_WIDTH: loaded word.
- `data_valid` out 1: one-cycle pulse; data-port access is complete.
- `addr_err` out 1: sticky flag for misaligned or out-of-range accesses.

## Operation
- Word index is `addr[log2(MEM_SIZE)+1:2]`.
- An access is bad if `addr[1:0]` ≠ 0 or any bit above the index is set. A bad access:
  - sets `addr_err`, which stays set until reset;
  - on a read, returns 0;
  - on a write, leaves the RAM unchanged;
  - still completes with a normal `valid` pulse.
- Handshake:
  - The requester holds its enable, address and write value stable until it sees `valid`.
  - In the `valid` cycle it may drop the enable or present a new request.
  - A request with its enable still high in its own `valid` cycle is treated as a new request.
- FSM states:
  - IDLE: no access in flight.
  - SERV_I: instruction access completing.
  - SERV_D: data access completing.
- Grant rule, evaluated every cycle in any state:
  - Only I pending → grant I.
  - Only D pending → grant D.
  - Both pending → grant the port that was not granted most recently (round-robin bit `last_d`).
  - Neither pending → go to IDLE.
- The granted RAM access happens on the grant edge. The next state is SERV_I or SERV_D accordingly, and that port's `valid` is high in that state.
- Data port:
  - `read_en` and `write_en` both high: the write is performed, and `mem_read_val_data` returns the written value (write-first).
  - Write only: `mem_read_val_data` holds its previous value.
- `mem_read_val_instr` and `mem_read_val_data` hold their values between accesses.
- RAM contents are not cleared by reset.

## Timing
- Latency: request sampled at edge N with no contention → `valid` high during cycle N+1.
- Back-to-back requests from one port reach full throughput: one access per cycle.
- When both ports request continuously, grants alternate I, D, I, D…, so each port waits at most one extra cycle.
- Reset values:
  - state = IDLE
  - `instr_valid` = `data_valid` = 0
  - `mem_read_val_instr` = `mem_read_val_data` = 0
  - `addr_err` = 0
  - `last_d` = 1, so I wins the first conflict
- Reset mid-access: the in-flight access produces no `valid`. A write granted on the same edge that `reset` is sampled is not performed.
- A request deasserted before its grant is dropped silently and never produces `valid`.

## Configuration
- `UMEM_STAT_EN` defined: adds an output `conflict_cnt`, 16 bits, reset to 0.
  - Increments on each cycle in which both ports are pending.
  - Saturates at 16'hFFFF.
- `UMEM_STAT_EN` undefined: the port and counter do not exist. Arbitration behaviour is identical either way.

## Test plan
- Store then load, data port only:
  - Store 32'hDEADBEEF to 0x10; `data_valid` pulses 1 cycle later.
  - Load 0x10 returns 32'hDEADBEEF with latency 1.
- Back-to-back instruction fetches, I port only:
  - Fetch 0x0, 0x4, 0x8 with `read_en` held high.
  - `instr_valid` is high 3 consecutive cycles with the matching words.
- Contention:
  - Both ports request continuously from reset.
  - Grants go I, D, I, D; no port waits more than 1 cycle.
  - `conflict_cnt` increments every cycle (when `UMEM_STAT_EN` is defined).
- Bad addresses:
  - Load 0x13 returns 0 and sets `addr_err`.
  - Store 32'h1 to 0x400 (MEM_SIZE=256) leaves every word unchanged; `addr_err` stays 1 until reset.
- Simultaneous read+write to 0x20 with 32'h12345678: `mem_read_val_data` = 32'h12345678 in the `valid` cycle.
- Reset asserted during SERV_D: no `valid` in the next cycle, all outputs 0, and RAM contents preserved.
